csr_access_unit: RTL and testbench
==================================

CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

Interface
REQ-001 Parameter DATA_W, default 32, CSR data and operand width.
REQ-002 Parameter ADDR_W, default 12, CSR address width.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset; the polarity and synchronicity are fixed as asynchronous and active-high.
REQ-005 op_valid_i  in  1  upstream decode presents a CSR instruction.
REQ-006 op_ready_o  out  1  unit can accept an op; high only in IDLE.
REQ-007 op_funct3_i  in  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
REQ-008 op_csr_addr_i  in  ADDR_W  target CSR address.
REQ-009 op_rs1_data_i  in  DATA_W  rs1 value for the register forms.
REQ-010 op_rs1_idx_i  in  5  rs1 index, or the zimm field for the immediate forms.
REQ-011 op_rd_idx_i  in  5  destination register index.
REQ-012 csr_read_enable_o  out  1  read strobe to the CSR register file.
REQ-013 csr_write_enable_o  out  1  write strobe to the CSR register file.
REQ-014 csr_address_o  out  ADDR_W  latched CSR address.
REQ-015 csr_write_data_o  out  DATA_W  computed new CSR value.
REQ-016 csr_read_data_i  in  DATA_W  registered read data; valid the cycle after csr_read_enable_o.
REQ-017 res_valid_o  out  1  a result is available for writeback.
REQ-018 res_ready_i  in  1  the writeback stage accepts the result.
REQ-019 res_rd_idx_o  out  5  latched rd index.
REQ-020 res_data_o  out  DATA_W  old CSR value, zero-extended to DATA_W.
REQ-021 res_illegal_o  out  1  the op was illegal; qualified by res_valid_o.

Function
REQ-022 FSM states and transitions:
- IDLE -> READ on op_valid_i && op_ready_o.
- READ -> MODIFY.
- MODIFY -> WRITE if a write is required, else RESP.
- WRITE -> RESP.
- RESP -> IDLE on res_ready_i.
REQ-023 The accept handshake latches funct3, addr, rs1 data/idx and rd idx; the inputs are then ignored until the unit returns to IDLE.
REQ-024 Operand: the immediate forms use {27'b0, rs1_idx}; the register forms use rs1 data.
REQ-025 READ asserts csr_read_enable_o for exactly one cycle.
REQ-026 MODIFY latches csr_read_data_i as the old value and computes the new value:
- RW: new = operand.
- RS: new = old | operand.
- RC: new = old & ~operand.
REQ-027 A write is required for RW/RWI always, and for RS/RC/RSI/RCI only when rs1_idx != 0.
REQ-028 WRITE asserts csr_write_enable_o for exactly one cycle, with csr_write_data_o = new.
REQ-029 csr_address_o holds the latched address from READ through WRITE, and is 0 otherwise.
REQ-030 Illegal ops go IDLE -> RESP directly, with no read or write strobe, res_illegal_o=1 and res_data_o=0:
- funct3 000 or 100.
- addr[11:10]==2'b11 with a write required.
REQ-031 Latency, with accept at edge E0:
- res_valid_o rises after E3 when no write is performed.
- res_valid_o rises after E4 when a write is performed.
- res_valid_o rises after E1 for illegal ops.
REQ-032 res_valid_o, res_data_o, res_rd_idx_o and res_illegal_o hold stable while res_valid_o=1 && res_ready_i=0.
REQ-033 RESP with res_ready_i=1 returns to IDLE; a new op is accepted no earlier than the following cycle.
REQ-034 The read and write strobes are never high in the same cycle.

Reset
REQ-035 While rst_i=1, the unit is in IDLE and all outputs except op_ready_o are 0; op_ready_o=1 after release.
REQ-036 A reset asserted in any state aborts the op immediately: no strobe is issued after the reset edge and the latched op is discarded.

Verification
REQ-037 CSRRW, addr 0x305, rs1=0x0000_1000, CSR holds 0xAAAA -> one read strobe, then a write of 0x1000 to 0x305; res_data_o=0xAAAA with res_valid_o 4 cycles after accept.
REQ-038 CSRRS, addr 0x300, rs1_idx=0 -> read only, no write strobe; res_data_o = the mstatus value 3 cycles after accept.
REQ-039 CSRRCI, addr 0x304, zimm=5, mie=0xF -> write of 0xA.
REQ-040 funct3=100, or CSRRW to 0xC00 -> no strobes; res_illegal_o=1 one cycle after accept.
REQ-041 res_ready_i held low for 3 cycles in RESP -> outputs stable, op_ready_o=0, then IDLE after res_ready_i=1.
REQ-042 rst_i pulsed in MODIFY -> csr_write_enable_o never asserts; next-cycle outputs are 0 and op_ready_o=1 after release.

Source files
------------

// File: rtl/csr_access_unit.sv
// CSR access unit: sequences a CSR read-modify-write for Zicsr instructions.
// Decode presents an op; the unit reads the CSR, computes the new value,
// optionally writes it back, and returns the old value for writeback to rd.
module csr_access_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // Op request from decode
  input  logic              op_valid_i,
  output logic              op_ready_o,
  input  logic [2:0]        op_funct3_i,
  input  logic [ADDR_W-1:0] op_csr_addr_i,
  input  logic [DATA_W-1:0] op_rs1_data_i,
  input  logic [4:0]        op_rs1_idx_i,
  input  logic [4:0]        op_rd_idx_i,
  // CSR register file port
  output logic              csr_read_enable_o,
  output logic              csr_write_enable_o,
  output logic [ADDR_W-1:0] csr_address_o,
  output logic [DATA_W-1:0] csr_write_data_o,
  input  logic [DATA_W-1:0] csr_read_data_i,
  // Result to writeback
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [4:0]        res_rd_idx_o,
  output logic [DATA_W-1:0] res_data_o,
  output logic              res_illegal_o
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    MODIFY,
    WRITE,
    RESP
  } state_t;

  state_t state;
  state_t state_next;

  // Op fields captured at accept
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rs1_data_q;
  logic [4:0]        rs1_idx_q;
  logic [4:0]        rd_idx_q;
  logic              write_req_q;
  logic              illegal_q;

  // Old and new CSR values
  logic [DATA_W-1:0] old_q;
  logic [DATA_W-1:0] new_q;

  logic              accept;
  logic              in_write_req;
  logic              in_illegal;
  logic [DATA_W-1:0] operand;
  logic [DATA_W-1:0] modify_val;

  assign accept = op_valid_i && (state == IDLE);

  // Decode of the incoming op: register forms write unless they only set/clear
  // with x0, and the top address quadrant (11) is read-only.
  assign in_write_req = (op_funct3_i[1:0] == 2'b01) || (op_rs1_idx_i != 5'd0);
  assign in_illegal   = (op_funct3_i[1:0] == 2'b00) ||
                        ((op_csr_addr_i[ADDR_W-1:ADDR_W-2] == 2'b11) && in_write_req);

  // Immediate forms (funct3[2]=1) use the zero-extended zimm field
  assign operand = funct3_q[2] ? DATA_W'(rs1_idx_q) : rs1_data_q;

  // New CSR value from the old value arriving this cycle and the operand
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    modify_val = operand;
    case (funct3_q[1:0])
      2'b10:   modify_val = csr_read_data_i | operand;
      2'b11:   modify_val = csr_read_data_i & ~operand;
      default: modify_val = operand;
    endcase
  end

  // State register; reset aborts any op in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = in_illegal ? RESP : READ;
      READ:    state_next = MODIFY;
      MODIFY:  state_next = write_req_q ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    if (res_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Op capture at accept, old/new value capture in MODIFY
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      funct3_q    <= '0;
      addr_q      <= '0;
      rs1_data_q  <= '0;
      rs1_idx_q   <= '0;
      rd_idx_q    <= '0;
      write_req_q <= 1'b0;
      illegal_q   <= 1'b0;
      old_q       <= '0;
      new_q       <= '0;
    end else begin
      if (accept) begin
        funct3_q    <= op_funct3_i;
        addr_q      <= op_csr_addr_i;
        rs1_data_q  <= op_rs1_data_i;
        rs1_idx_q   <= op_rs1_idx_i;
        rd_idx_q    <= op_rd_idx_i;
        write_req_q <= in_write_req;
        illegal_q   <= in_illegal;
        // Illegal ops report zero as the old value
        old_q       <= '0;
      end
      if (state == MODIFY) begin
        old_q <= csr_read_data_i;
        new_q <= modify_val;
      end
    end
  end

  // Outputs are decoded from state so strobes last exactly one state and
  // everything drops to zero the moment reset forces IDLE.
  always_comb begin
    op_ready_o         = (state == IDLE);
    csr_read_enable_o  = (state == READ);
    csr_write_enable_o = (state == WRITE);
    csr_address_o      = '0;
    csr_write_data_o   = '0;
    res_valid_o        = (state == RESP);
    res_rd_idx_o       = '0;
    res_data_o         = '0;
    res_illegal_o      = 1'b0;
    if ((state == READ) || (state == MODIFY) || (state == WRITE)) begin
      csr_address_o = addr_q;
    end
    if (state == WRITE) begin
      csr_write_data_o = new_q;
    end
    if (state == RESP) begin
      res_rd_idx_o  = rd_idx_q;
      res_data_o    = old_q;
      res_illegal_o = illegal_q;
    end
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed testbench for csr_access_unit with a small CSR file model.
module tb_csr_access_unit;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op_funct3;
  logic [11:0] op_addr;
  logic [31:0] op_rs1_data;
  logic [4:0]  op_rs1_idx;
  logic [4:0]  op_rd_idx;
  logic        csr_re;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        res_valid;
  logic        res_ready;
  logic [4:0]  res_rd_idx;
  logic [31:0] res_data;
  logic        res_illegal;

  // CSR file model and strobe monitor
  logic [31:0] csr_mem [0:4095];
  logic        load_en;
  logic [11:0] load_addr;
  logic [31:0] load_data;
  int          rd_cnt;
  int          wr_cnt;
  logic [11:0] last_rd_addr;
  logic [11:0] last_wr_addr;
  logic [31:0] last_wr_data;
  logic        both_seen;

  int checks;
  int errors;

  csr_access_unit #(.DATA_W(32), .ADDR_W(12)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .op_valid_i         (op_valid),
    .op_ready_o         (op_ready),
    .op_funct3_i        (op_funct3),
    .op_csr_addr_i      (op_addr),
    .op_rs1_data_i      (op_rs1_data),
    .op_rs1_idx_i       (op_rs1_idx),
    .op_rd_idx_i        (op_rd_idx),
    .csr_read_enable_o  (csr_re),
    .csr_write_enable_o (csr_we),
    .csr_address_o      (csr_addr),
    .csr_write_data_o   (csr_wdata),
    .csr_read_data_i    (csr_rdata),
    .res_valid_o        (res_valid),
    .res_ready_i        (res_ready),
    .res_rd_idx_o       (res_rd_idx),
    .res_data_o         (res_data),
    .res_illegal_o      (res_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rd_cnt       = 0;
    wr_cnt       = 0;
    both_seen    = 1'b0;
    last_rd_addr = '0;
    last_wr_addr = '0;
    last_wr_data = '0;
    csr_rdata    = '0;
  end

  // Registered-read CSR file plus strobe bookkeeping
  always @(posedge clk) begin
    if (load_en) csr_mem[load_addr] <= load_data;
    else if (csr_we) csr_mem[csr_addr] <= csr_wdata;
    if (csr_re) csr_rdata <= csr_mem[csr_addr];
    if (csr_re) begin
      rd_cnt       <= rd_cnt + 1;
      last_rd_addr <= csr_addr;
    end
    if (csr_we) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= csr_addr;
      last_wr_data <= csr_wdata;
    end
    if (csr_re && csr_we) both_seen <= 1'b1;
  end

  task automatic load_csr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(posedge clk);
    #1 load_en = 1'b0;
  endtask

  // Present one op from IDLE; lat = edges from accept until res_valid is seen
  task automatic run_op(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] d,
                        input logic [4:0] idx, input logic [4:0] rd, output int lat);
    @(negedge clk);
    op_valid    = 1'b1;
    op_funct3   = f3;
    op_addr     = a;
    op_rs1_data = d;
    op_rs1_idx  = idx;
    op_rd_idx   = rd;
    @(posedge clk);
    #1 op_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    checks++; if (csr_re !== 1'b0 || csr_we !== 1'b0) begin errors++; $display("FAIL reset_strobes got re=%b we=%b want 0 0", csr_re, csr_we); end
    checks++; if (csr_addr !== 12'h0 || csr_wdata !== 32'h0) begin errors++; $display("FAIL reset_csr_bus got addr=%h data=%h want 0 0", csr_addr, csr_wdata); end
    checks++; if (res_data !== 32'h0 || res_rd_idx !== 5'd0 || res_illegal !== 1'b0) begin errors++; $display("FAIL reset_result got data=%h rd=%0d ill=%b want 0 0 0", res_data, res_rd_idx, res_illegal); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_op_ready got %b want 1", op_ready); end
  endtask

  task automatic test_rw();
    int lat;
    int rd0, wr0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    run_op(3'b001, 12'h305, 32'h0000_1000, 5'd3, 5'd7, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rw_latency got %0d want 4", lat); end
    checks++; if (res_data !== 32'h0000_AAAA) begin errors++; $display("FAIL rw_res_data got %h want 0000aaaa", res_data); end
    checks++; if (res_rd_idx !== 5'd7 || res_illegal !== 1'b0) begin errors++; $display("FAIL rw_res_fields got rd=%0d ill=%b want 7 0", res_rd_idx, res_illegal); end
    checks++; if (rd_cnt - rd0 !== 1 || wr_cnt - wr0 !== 1) begin errors++; $display("FAIL rw_strobe_count got rd=%0d wr=%0d want 1 1", rd_cnt - rd0, wr_cnt - wr0); end
    checks++; if (last_rd_addr !== 12'h305 || last_wr_addr !== 12'h305) begin errors++; $display("FAIL rw_strobe_addr got rd=%h wr=%h want 305 305", last_rd_addr, last_wr_addr); end
    checks++; if (last_wr_data !== 32'h0000_1000) begin errors++; $display("FAIL rw_write_data got %h want 00001000", last_wr_data); end
    checks++; if (csr_addr !== 12'h0) begin errors++; $display("FAIL rw_addr_in_resp got %h want 000", csr_addr); end
    release_result();
    checks++; if (op_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL rw_back_idle got ready=%b valid=%b want 1 0", op_ready, res_valid); end
  endtask

  task automatic test_rs_read_only();
    int lat;
    int rd0, wr0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    run_op(3'b010, 12'h300, 32'hFFFF_FFFF, 5'd0, 5'd2, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rs0_latency got %0d want 3", lat); end
    checks++; if (res_data !== 32'h0000_1888) begin errors++; $display("FAIL rs0_res_data got %h want 00001888", res_data); end
    checks++; if (rd_cnt - rd0 !== 1 || wr_cnt - wr0 !== 0) begin errors++; $display("FAIL rs0_strobe_count got rd=%0d wr=%0d want 1 0", rd_cnt - rd0, wr_cnt - wr0); end
    release_result();
  endtask

  // Set/clear variants in register and immediate form; expected values are hand-computed
  task automatic test_modify_ops();
    int lat;
    int wr0;
    // CSRRCI 0x304 zimm=5, mie=0xF -> 0xA
    wr0 = wr_cnt;
    run_op(3'b111, 12'h304, 32'hFFFF_FFFF, 5'd5, 5'd1, lat);
    checks++; if (lat !== 4 || res_data !== 32'hF) begin errors++; $display("FAIL rci_result got lat=%0d data=%h want 4 0000000f", lat, res_data); end
    checks++; if (wr_cnt - wr0 !== 1 || last_wr_data !== 32'hA) begin errors++; $display("FAIL rci_write got n=%0d data=%h want 1 0000000a", wr_cnt - wr0, last_wr_data); end
    release_result();
    // CSRRS 0x305 rs1=0xF0 (x2): 0x1000 -> 0x10F0
    run_op(3'b010, 12'h305, 32'h0000_00F0, 5'd2, 5'd4, lat);
    checks++; if (res_data !== 32'h1000 || last_wr_data !== 32'h10F0) begin errors++; $display("FAIL rs_values got old=%h new=%h want 00001000 000010f0", res_data, last_wr_data); end
    release_result();
    // CSRRC 0x305 rs1=0x10 (x4): 0x10F0 -> 0x10E0
    run_op(3'b011, 12'h305, 32'h0000_0010, 5'd4, 5'd5, lat);
    checks++; if (res_data !== 32'h10F0 || last_wr_data !== 32'h10E0) begin errors++; $display("FAIL rc_values got old=%h new=%h want 000010f0 000010e0", res_data, last_wr_data); end
    release_result();
    // CSRRSI 0x304 zimm=0x11: 0xA -> 0x1B, rs1 data must be ignored
    run_op(3'b110, 12'h304, 32'hDEAD_BEEF, 5'h11, 5'd6, lat);
    checks++; if (res_data !== 32'hA || last_wr_data !== 32'h1B) begin errors++; $display("FAIL rsi_values got old=%h new=%h want 0000000a 0000001b", res_data, last_wr_data); end
    release_result();
    // CSRRWI 0x340 zimm=0x1F: writes 0x1F, returns 0x12345678
    run_op(3'b101, 12'h340, 32'hDEAD_BEEF, 5'h1F, 5'd8, lat);
    checks++; if (res_data !== 32'h1234_5678 || last_wr_data !== 32'h1F || last_wr_addr !== 12'h340) begin errors++; $display("FAIL rwi_values got old=%h new=%h addr=%h want 12345678 0000001f 340", res_data, last_wr_data, last_wr_addr); end
    release_result();
  endtask

  task automatic test_illegal();
    int lat;
    int rd0, wr0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    run_op(3'b100, 12'h305, 32'h1, 5'd1, 5'd9, lat);
    checks++; if (lat !== 1 || res_illegal !== 1'b1 || res_data !== 32'h0) begin errors++; $display("FAIL ill_f100 got lat=%0d ill=%b data=%h want 1 1 0", lat, res_illegal, res_data); end
    checks++; if (res_rd_idx !== 5'd9) begin errors++; $display("FAIL ill_rd_idx got %0d want 9", res_rd_idx); end
    release_result();
    run_op(3'b000, 12'h300, 32'h1, 5'd1, 5'd9, lat);
    checks++; if (lat !== 1 || res_illegal !== 1'b1) begin errors++; $display("FAIL ill_f000 got lat=%0d ill=%b want 1 1", lat, res_illegal); end
    release_result();
    run_op(3'b001, 12'hC00, 32'h1, 5'd1, 5'd9, lat);
    checks++; if (lat !== 1 || res_illegal !== 1'b1 || res_data !== 32'h0) begin errors++; $display("FAIL ill_rw_ro got lat=%0d ill=%b data=%h want 1 1 0", lat, res_illegal, res_data); end
    release_result();
    checks++; if (rd_cnt - rd0 !== 0 || wr_cnt - wr0 !== 0) begin errors++; $display("FAIL ill_strobes got rd=%0d wr=%0d want 0 0", rd_cnt - rd0, wr_cnt - wr0); end
    // Read-only space is fine when nothing is written
    run_op(3'b010, 12'hC00, 32'hFFFF_FFFF, 5'd0, 5'd3, lat);
    checks++; if (lat !== 3 || res_illegal !== 1'b0 || res_data !== 32'h55) begin errors++; $display("FAIL ro_read got lat=%0d ill=%b data=%h want 3 0 00000055", lat, res_illegal, res_data); end
    release_result();
  endtask

  task automatic test_backpressure();
    int lat;
    int rd0;
    rd0 = rd_cnt;
    run_op(3'b010, 12'h300, 32'h0, 5'd0, 5'd9, lat);
    for (int i = 0; i < 3; i++) begin
      // A competing op must be ignored while the result is pending
      op_valid    = 1'b1;
      op_funct3   = 3'b001;
      op_addr     = 12'h305;
      op_rs1_idx  = 5'd1;
      op_rd_idx   = 5'd1;
      @(posedge clk);
      #1;
      checks++; if (res_valid !== 1'b1 || op_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_%0d got valid=%b ready=%b want 1 0", i, res_valid, op_ready); end
      checks++; if (res_data !== 32'h1888 || res_rd_idx !== 5'd9 || res_illegal !== 1'b0) begin errors++; $display("FAIL bp_stable_%0d got data=%h rd=%0d ill=%b want 00001888 9 0", i, res_data, res_rd_idx, res_illegal); end
    end
    op_valid = 1'b0;
    release_result();
    checks++; if (op_ready !== 1'b1 || res_valid !== 1'b0 || rd_cnt - rd0 !== 1) begin errors++; $display("FAIL bp_release got ready=%b valid=%b reads=%0d want 1 0 1", op_ready, res_valid, rd_cnt - rd0); end
  endtask

  task automatic test_reset_abort();
    int lat;
    int wr0;
    wr0 = wr_cnt;
    @(negedge clk);
    op_valid    = 1'b1;
    op_funct3   = 3'b001;
    op_addr     = 12'h305;
    op_rs1_data = 32'h0000_0777;
    op_rs1_idx  = 5'd7;
    op_rd_idx   = 5'd7;
    @(posedge clk);      // accept -> READ
    #1 op_valid = 1'b0;
    @(posedge clk);      // READ -> MODIFY
    #1 rst = 1'b1;
    #1;
    checks++; if (csr_we !== 1'b0 || csr_re !== 1'b0 || csr_addr !== 12'h0 || res_valid !== 1'b0) begin errors++; $display("FAIL abort_outputs got we=%b re=%b addr=%h valid=%b want 0 0 0 0", csr_we, csr_re, csr_addr, res_valid); end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (op_ready !== 1'b1 || wr_cnt - wr0 !== 0) begin errors++; $display("FAIL abort_idle got ready=%b writes=%0d want 1 0", op_ready, wr_cnt - wr0); end
    // CSR must still hold the value from before the aborted op
    run_op(3'b010, 12'h305, 32'h0, 5'd0, 5'd1, lat);
    checks++; if (res_data !== 32'h10E0) begin errors++; $display("FAIL abort_csr_kept got %h want 000010e0", res_data); end
    release_result();
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    op_valid    = 1'b0;
    op_funct3   = '0;
    op_addr     = '0;
    op_rs1_data = '0;
    op_rs1_idx  = '0;
    op_rd_idx   = '0;
    res_ready   = 1'b0;
    load_en     = 1'b0;
    load_addr   = '0;
    load_data   = '0;
    test_reset();
    load_csr(12'h305, 32'h0000_AAAA);
    load_csr(12'h300, 32'h0000_1888);
    load_csr(12'h304, 32'h0000_000F);
    load_csr(12'h340, 32'h1234_5678);
    load_csr(12'hC00, 32'h0000_0055);
    test_rw();
    test_rs_read_only();
    test_modify_ops();
    test_illegal();
    test_backpressure();
    test_reset_abort();
    checks++; if (both_seen !== 1'b0) begin errors++; $display("FAIL strobe_overlap got %b want 0", both_seen); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
